fifo_rd_packer: RTL

- Downstream consumer of the sync FIFO's read port.
- Pops DATA_WIDTH-bit words from the FIFO and packs PACK_RATIO of them, lane 0 in the LSBs, into one wide word.
- Presents the packed word on a valid/ready master stream.
- A flush request emits a partial word with a lane-keep mask.
- Sits between the FIFO and the wide datapath sink.

---
 rtl/fifo_rd_packer.sv | 118 +++++++++++
 1 files changed

// File: rtl/fifo_rd_packer.sv
// Pops narrow words from a registered-read FIFO and packs PACK_RATIO of them
// (lane 0 in the LSBs) into one wide word on a valid/ready stream.
module fifo_rd_packer #(
  parameter int DATA_WIDTH = 8,
  parameter int PACK_RATIO = 4
) (
  input  logic                             clk,
  input  logic                             rst_n,
  output logic                             rd_en,
  input  logic [DATA_WIDTH-1:0]            data_out,
  input  logic                             empty,
  input  logic                             flush,
  output logic [DATA_WIDTH*PACK_RATIO-1:0] m_data,
  output logic [PACK_RATIO-1:0]            m_keep,
  output logic                             m_valid,
  input  logic                             m_ready,
  output logic                             busy,
  output logic [15:0]                      words_out
);

  localparam int OUT_WIDTH = DATA_WIDTH * PACK_RATIO;
  localparam int CW = $clog2(PACK_RATIO + 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(PACK_RATIO);

  logic [CW-1:0]         r_acc_cnt;
  logic                  r_pend;
  logic                  r_flush_pend;
  logic                  r_m_valid;
  logic [OUT_WIDTH-1:0]  r_m_data;
  logic [PACK_RATIO-1:0] r_m_keep;
  logic [15:0]           r_words_out;

  logic [CW-1:0]         w_cnt_cap;
  logic [CW-1:0]         w_acc_next;
  logic                  w_full;
  logic                  w_out_free;
  logic                  w_handshake;
  logic                  w_flush_go;
  logic                  w_load;
  logic                  w_rd_en;
  logic [PACK_RATIO-1:0] w_keep_next;
  logic [OUT_WIDTH-1:0]  w_word_next;

  // Lane count once this cycle's in-flight read (if any) has been captured.
  assign w_cnt_cap   = r_acc_cnt + CW'(r_pend);
  assign w_full      = (w_cnt_cap == FULL_CNT);
  assign w_out_free  = !r_m_valid || m_ready;
  assign w_handshake = r_m_valid && m_ready;
  assign w_flush_go  = r_flush_pend && !r_pend && w_out_free;
  assign w_load      = w_out_free && (w_full || (w_flush_go && (r_acc_cnt != '0)));
  assign w_acc_next  = w_load ? '0 : w_cnt_cap;

  // A word leaving the accumulator this cycle frees its lanes, so the next
  // read can issue immediately and keep pops back-to-back.
  assign w_rd_en = rst_n && !empty && !r_flush_pend && (w_acc_next < FULL_CNT);

  generate
    for (genvar gi = 0; gi < PACK_RATIO; gi++) begin : g_lane
      logic [DATA_WIDTH-1:0] r_lane;
      logic                  w_wr;
      logic [DATA_WIDTH-1:0] w_lane_cur;

      assign w_wr        = r_pend && (r_acc_cnt == CW'(gi));
      assign w_lane_cur  = w_wr ? data_out : r_lane;
      assign w_keep_next[gi] = (CW'(gi) < w_cnt_cap);
      assign w_word_next[gi*DATA_WIDTH +: DATA_WIDTH] = w_keep_next[gi] ? w_lane_cur : '0;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_lane <= '0;
        end else if (w_wr) begin
          r_lane <= data_out;
        end
      end
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc_cnt    <= '0;
      r_pend       <= 1'b0;
      r_flush_pend <= 1'b0;
      r_m_valid    <= 1'b0;
      r_m_data     <= '0;
      r_m_keep     <= '0;
      r_words_out  <= '0;
    end else begin
      r_pend    <= w_rd_en;
      r_acc_cnt <= w_acc_next;

      if (w_flush_go) begin
        r_flush_pend <= 1'b0;
      end else if (flush) begin
        r_flush_pend <= 1'b1;
      end

      if (w_load) begin
        r_m_data  <= w_word_next;
        r_m_keep  <= w_keep_next;
        r_m_valid <= 1'b1;
      end else if (w_handshake) begin
        r_m_valid <= 1'b0;
      end

      if (w_handshake) begin
        r_words_out <= r_words_out + 16'd1;
      end
    end
  end

  assign rd_en     = w_rd_en;
  assign m_data    = r_m_data;
  assign m_keep    = r_m_keep;
  assign m_valid   = r_m_valid;
  assign words_out = r_words_out;
  assign busy      = (r_acc_cnt != '0) || r_pend || r_m_valid || r_flush_pend;

endmodule
